// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants shared by the sync generator, its interface and the bench.
package vga_timing_pkg;

  localparam int CNT_W     = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_DISPLAY + H_FP;
  localparam int HS_END    = HS_START + H_SYNC - 1;
  localparam int VS_START  = V_DISPLAY + V_FP;
  localparam int VS_END    = VS_START + V_SYNC - 1;

  // Bits carried by the delay line, already at output polarity.
  typedef struct packed {
    logic vid;
    logic hs;
    logic vs;
  } sync_bits_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster-timing bundle from the sync generator (master) to the text stage (slave).
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             p_tick;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             video_on;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;

  // p_tick acts as the valid strobe: pix_x/pix_y and the delayed flags are
  // meaningful on every clk where p_tick=1; there is no ready/back-pressure.
  modport master (
    output p_tick, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
  );

  modport slave (
    input p_tick, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_sync_delay.sv
// Enable-gated shift register of configurable depth with a per-bit reset value.
module sync_delay #(
  parameter int           DEPTH   = 2,
  parameter int           W       = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Pixel-tick divider, raster counters and latency-matched sync/blank flags for the text stage.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY_P = H_DISPLAY,
  parameter int H_FP_P      = H_FP,
  parameter int H_SYNC_P    = H_SYNC,
  parameter int H_BP_P      = H_BP,
  parameter int V_DISPLAY_P = V_DISPLAY,
  parameter int V_FP_P      = V_FP,
  parameter int V_SYNC_P    = V_SYNC,
  parameter int V_BP_P      = V_BP,
  parameter int CLK_DIV     = 2,
  parameter int SYNC_DLY    = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  vga_sync_gen_if.master vga
);

  localparam int HT   = H_DISPLAY_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int VT   = V_DISPLAY_P + V_FP_P + V_SYNC_P + V_BP_P;
  localparam int HS_S = H_DISPLAY_P + H_FP_P;
  localparam int HS_E = HS_S + H_SYNC_P - 1;
  localparam int VS_S = V_DISPLAY_P + V_FP_P;
  localparam int VS_E = VS_S + V_SYNC_P - 1;

  localparam sync_bits_t IDLE_BITS = '{vid: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  logic tick;

  generate
    if (CLK_DIV > 1) begin : g_div
      logic [2:0] div;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       div <= '0;
        else if (div >= 3'(CLK_DIV-1))  div <= '0;
        else                            div <= div + 3'd1;
      end

      assign tick = (div == 3'(CLK_DIV-1));
    end else begin : g_nodiv
      // Every clk is a pixel; held high whenever reset is released.
      assign tick = rst;
    end
  endgenerate

  logic [CNT_W-1:0] x_q, y_q;
  logic             x_last, y_last;

  // >= rather than == so any out-of-range value recovers on the next tick.
  assign x_last = (x_q >= CNT_W'(HT-1));
  assign y_last = (y_q >= CNT_W'(VT-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (tick) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  logic       vid_raw, hs_raw, vs_raw;
  sync_bits_t raw_bits, dly_bits;

  always_comb begin
    vid_raw  = (x_q < CNT_W'(H_DISPLAY_P)) && (y_q < CNT_W'(V_DISPLAY_P));
    hs_raw   = (x_q >= CNT_W'(HS_S)) && (x_q <= CNT_W'(HS_E));
    vs_raw   = (y_q >= CNT_W'(VS_S)) && (y_q <= CNT_W'(VS_E));
    raw_bits = '{vid: vid_raw,
                 hs:  hs_raw ? SYNC_POL : ~SYNC_POL,
                 vs:  vs_raw ? SYNC_POL : ~SYNC_POL};
  end

  sync_delay #(
    .DEPTH   (SYNC_DLY),
    .W       (3),
    .RST_VAL (IDLE_BITS)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .en  (tick),
    .d   (raw_bits),
    .q   (dly_bits)
  );

  assign vga.p_tick      = tick;
  assign vga.pix_x       = x_q;
  assign vga.pix_y       = y_q;
  assign vga.video_on    = dly_bits.vid;
  assign vga.hsync       = dly_bits.hs;
  assign vga.vsync       = dly_bits.vs;
  assign vga.line_start  = tick && (x_q == CNT_W'(HT-1));
  assign vga.frame_start = tick && (x_q == CNT_W'(HT-1)) && (y_q == CNT_W'(VT-1));

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: default 640x480 instance (div 2, delay 2) and a shrunken raster instance (div 1, delay 1, active-high sync).
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int A_DIV = 2, A_DLY = 2;
  localparam int B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VD = 4, B_VF = 1, B_VS = 2, B_VB = 1;
  localparam int B_DIV = 1, B_DLY = 1;
  localparam bit B_POL = 1'b1;
  localparam int W = 25;

  logic clk, rst_a, rst_b;
  int   errors = 0, checks = 0;
  bit   done_a = 0, done_b = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  vga_sync_gen_if vga_a ();
  vga_sync_gen_if vga_b ();

  vga_sync_gen #(.CLK_DIV(A_DIV), .SYNC_DLY(A_DLY), .SYNC_POL(1'b0)) dut_a (
    .clk(clk), .rst(rst_a), .vga(vga_a)
  );

  vga_sync_gen #(
    .H_DISPLAY_P(B_HD), .H_FP_P(B_HF), .H_SYNC_P(B_HS), .H_BP_P(B_HB),
    .V_DISPLAY_P(B_VD), .V_FP_P(B_VF), .V_SYNC_P(B_VS), .V_BP_P(B_VB),
    .CLK_DIV(B_DIV), .SYNC_DLY(B_DLY), .SYNC_POL(B_POL)
  ) dut_b (
    .clk(clk), .rst(rst_b), .vga(vga_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected view of the n-th pixel tick after reset release:
  // {pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start}.
  function automatic logic [W-1:0] exp_vec(input int n, input int hd, input int hf, input int hs,
                                            input int hb, input int vd, input int vf, input int vs,
                                            input int vb, input int dly, input bit pol);
    int ht, vt, x, y, m, mx, my;
    logic vid, hsv, vsv, ls, fs;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    x  = n % ht;
    y  = (n / ht) % vt;
    ls = (x == ht - 1);
    fs = ls && (y == vt - 1);
    if (n < dly) begin
      vid = 1'b0; hsv = ~pol; vsv = ~pol;
    end else begin
      m   = n - dly;
      mx  = m % ht;
      my  = (m / ht) % vt;
      vid = (mx < hd) && (my < vd);
      hsv = ((mx >= hd + hf) && (mx < hd + hf + hs)) ? pol : ~pol;
      vsv = ((my >= vd + vf) && (my < vd + vf + vs)) ? pol : ~pol;
    end
    return {10'(x), 10'(y), vid, hsv, vsv, ls, fs};
  endfunction

  function automatic logic [W-1:0] get_a();
    return {vga_a.pix_x, vga_a.pix_y, vga_a.video_on, vga_a.hsync, vga_a.vsync,
            vga_a.line_start, vga_a.frame_start};
  endfunction

  function automatic logic [W-1:0] get_b();
    return {vga_b.pix_x, vga_b.pix_y, vga_b.video_on, vga_b.hsync, vga_b.vsync,
            vga_b.line_start, vga_b.frame_start};
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_vec(input string name, input int idx, input logic [W-1:0] got,
                           input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got x=%0d y=%0d vid/hs/vs/ls/fs=%b want x=%0d y=%0d vid/hs/vs/ls/fs=%b",
               name, idx, got[24:15], got[14:5], got[4:0], want[24:15], want[14:5], want[4:0]);
    end
  endtask

  // scoreboard monitors: p_tick is the valid strobe
  int gap_a = 0, pop_a = 0;
  always @(negedge clk) begin
    if (!rst_a) begin
      gap_a = 0;
      pop_a = 0;
    end else begin
      gap_a++;
      if (vga_a.p_tick || gap_a >= A_DIV) begin
        check("a_tick_spacing", gap_a, A_DIV);
        gap_a = 0;
      end else begin
        check("a_pulse_off_tick", {30'd0, vga_a.line_start, vga_a.frame_start}, 0);
      end
      if (vga_a.p_tick && exp_a.size() > 0) begin
        check_vec("a_tick", pop_a, get_a(), exp_a.pop_front());
        pop_a++;
      end
    end
  end

  int gap_b = 0, pop_b = 0;
  always @(negedge clk) begin
    if (!rst_b) begin
      gap_b = 0;
      pop_b = 0;
    end else begin
      gap_b++;
      if (vga_b.p_tick || gap_b >= B_DIV) begin
        check("b_tick_spacing", gap_b, B_DIV);
        gap_b = 0;
      end
      if (vga_b.p_tick && exp_b.size() > 0) begin
        check_vec("b_tick", pop_b, get_b(), exp_b.pop_front());
        pop_b++;
      end
    end
  end

  // driver tasks
  task automatic push_a(input int count);
    for (int n = 0; n < count; n++)
      exp_a.push_back(exp_vec(n, H_DISPLAY, H_FP, H_SYNC, H_BP, V_DISPLAY, V_FP, V_SYNC, V_BP,
                              A_DLY, 1'b0));
  endtask

  task automatic push_b(input int count);
    for (int n = 0; n < count; n++)
      exp_b.push_back(exp_vec(n, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_DLY, B_POL));
  endtask

  task automatic drain_a(input string name, input int limit);
    for (int k = 0; k < limit && exp_a.size() > 0; k++) @(posedge clk);
    check(name, exp_a.size(), 0);
  endtask

  task automatic drain_b(input string name, input int limit);
    for (int k = 0; k < limit && exp_b.size() > 0; k++) @(posedge clk);
    check(name, exp_b.size(), 0);
  endtask

  // Reset state A: counters 0, video_on 0, active-low syncs idle high, no pulses.
  localparam logic [W-1:0] RST_A = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  // Reset state B: active-high syncs idle low.
  localparam logic [W-1:0] RST_B = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin : stim_a
    logic [W-1:0] rv;
    rv = RST_A;
    rst_a = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("a_rst_ptick", vga_a.p_tick, 0);
    check_vec("a_rst_state", 0, get_a(), rv);
    // One full line plus the start of the next: x wrap, hsync window, line_start.
    push_a(1010);
    rst_a = 1'b1;
    drain_a("a_line_drain", 2300);
    // Run to (300,0), then reset asynchronously mid-cycle.
    @(posedge clk); #2;
    rst_a = 1'b0;
    #1;
    check_vec("a_rst_again", 0, get_a(), rv);
    repeat (2) @(posedge clk);
    #2;
    push_a(300);
    rst_a = 1'b1;
    drain_a("a_run300_drain", 700);
    #2;
    check("a_mid_x", vga_a.pix_x, 300);
    check("a_mid_y", vga_a.pix_y, 0);
    rst_a = 1'b0;
    #1;
    check("a_async_ptick", vga_a.p_tick, 0);
    check_vec("a_async_rst", 0, get_a(), rv);
    repeat (3) @(posedge clk);
    #2;
    push_a(40);
    rst_a = 1'b1;
    drain_a("a_restart_drain", 200);
    done_a = 1;
  end

  initial begin : stim_b
    logic [W-1:0] rv;
    rv = RST_B;
    rst_b = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("b_rst_ptick", vga_b.p_tick, 0);
    check_vec("b_rst_state", 0, get_b(), rv);
    // 15x8 raster: 120 ticks per frame, run 2.5 frames.
    push_b(300);
    rst_b = 1'b1;
    #1;
    check("b_ptick_held", vga_b.p_tick, 1);
    drain_b("b_frame_drain", 700);
    @(posedge clk); #2;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    push_b(70);
    rst_b = 1'b1;
    drain_b("b_run70_drain", 300);
    #2;
    // Tick 70 of a 15-wide raster: x = 70 mod 15 = 10, y = 70 div 15 = 4.
    check("b_mid_x", vga_b.pix_x, 10);
    check("b_mid_y", vga_b.pix_y, 4);
    rst_b = 1'b0;
    #1;
    check("b_async_ptick", vga_b.p_tick, 0);
    check_vec("b_async_rst", 0, get_b(), rv);
    repeat (2) @(posedge clk);
    #2;
    push_b(30);
    rst_b = 1'b1;
    drain_b("b_restart_drain", 200);
    done_b = 1;
  end

  // final report
  initial begin : report
    int k;
    for (k = 0; k < 20000 && !(done_a && done_b); k++) @(posedge clk);
    check("bench_completion", int'(done_a && done_b), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
